// File: rtl/uac_iis_spk_tx.sv
// I2S (Philips) speaker serializer: 64-BCLK frames of two 32-bit slots, fed by a
// one-deep holding register behind a valid/ready handshake.
module uac_iis_spk_tx #(
  parameter int BCLK_HALF = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic                 i_clk98304,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [1:0]           i_sample_width,
  input  logic                 i_smp_val,
  output logic                 o_smp_rdy,
  input  logic [SLOT_BITS-1:0] i_smp_l,
  input  logic [SLOT_BITS-1:0] i_smp_r,
  output logic                 o_spk_iis_bclk,
  output logic                 o_spk_iis_lrck,
  output logic                 o_spk_iis_data,
  output logic                 o_frame_start,
  output logic                 o_underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int PER_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(FRAME_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [DIV_W-1:0]        div_cnt;
  logic [PER_W-1:0]        per_cnt;
  logic [PER_W-1:0]        per_next;
  logic                    bclk;
  logic                    lrck;
  logic                    sdata;
  logic                    frame_start;
  logic                    underrun;
  logic [FRAME_BITS-1:0]   shift;
  logic [SLOT_BITS-1:0]    hold_l;
  logic [SLOT_BITS-1:0]    hold_r;
  logic                    hold_full;
  logic [SLOT_BITS-1:0]    mask;
  logic                    half_end;
  logic                    fall;
  logic                    go_idle;
  logic                    load;
  logic                    xfer;

  // Keep only the top 16/24/32 bits of each MSB-aligned slot.
  function automatic logic [SLOT_BITS-1:0] slot_mask(input logic [1:0] width);
    logic [SLOT_BITS-1:0] m;
    m = '1;
    case (width)
      2'd0:    m = m << (SLOT_BITS - 16);
      2'd1:    m = m << (SLOT_BITS - 24);
      default: m = '1;
    endcase
    return m;
  endfunction

  assign mask      = slot_mask(i_sample_width);
  assign half_end  = (div_cnt == DIV_LAST);
  assign o_smp_rdy = !hold_full && (state == RUN);
  assign xfer      = i_smp_val && o_smp_rdy;
  assign load      = fall && (per_next == '0);

  always_ff @(posedge i_clk98304 or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // fall marks the edge that opens a new BCLK period (bclk goes low next cycle).
  always_comb begin
    state_next = state;
    fall       = 1'b0;
    go_idle    = 1'b0;
    per_next   = per_cnt;
    case (state)
      IDLE: begin
        if (i_enable) begin
          state_next = RUN;
          fall       = 1'b1;
          per_next   = '0;
        end
      end
      RUN: begin
        if (half_end && bclk) begin
          if ((per_cnt == PER_LAST) && !i_enable) begin
            state_next = IDLE;
            go_idle    = 1'b1;
          end else begin
            fall     = 1'b1;
            per_next = per_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk98304 or posedge i_reset) begin
    if (i_reset) begin
      div_cnt     <= '0;
      per_cnt     <= '0;
      bclk        <= 1'b0;
      lrck        <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      shift       <= '0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (fall) begin
        div_cnt <= '0;
        bclk    <= 1'b0;
        per_cnt <= per_next;
        lrck    <= per_next[PER_W-1];
        // Emitting shift MSB before the reload gives the one-BCLK I2S delay:
        // period 0 carries the previous frame's last bit.
        sdata   <= shift[FRAME_BITS-1];
        if (load) begin
          shift       <= hold_full ? {hold_l & mask, hold_r & mask} : '0;
          frame_start <= 1'b1;
          underrun    <= !hold_full;
        end else begin
          shift <= shift << 1;
        end
      end else if ((state == RUN) && !go_idle) begin
        if (half_end) begin
          div_cnt <= '0;
          bclk    <= 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end else begin
        div_cnt <= '0;
        per_cnt <= '0;
        bclk    <= 1'b0;
        lrck    <= 1'b0;
        sdata   <= 1'b0;
        shift   <= '0;
      end
    end
  end

  // A load coinciding with a transfer sees the old (empty) hold; the new pair stays held.
  always_ff @(posedge i_clk98304 or posedge i_reset) begin
    if (i_reset) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else begin
      if ((state == IDLE) || go_idle) begin
        hold_full <= 1'b0;
      end else if (xfer) begin
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (xfer) begin
        hold_l <= i_smp_l;
        hold_r <= i_smp_r;
      end
    end
  end

  assign o_spk_iis_bclk = bclk;
  assign o_spk_iis_lrck = lrck;
  assign o_spk_iis_data = sdata;
  assign o_frame_start  = frame_start;
  assign o_underrun     = underrun;

endmodule

// File: tb/tb_uac_iis_spk_tx.sv
// Self-checking bench for uac_iis_spk_tx against a frame-level timeline model.
module tb_uac_iis_spk_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        val = 1'b0;
  logic [1:0]  width = 2'd2;
  logic [31:0] sl = '0;
  logic [31:0] sr = '0;
  logic        rdy, bclk, lrck, sdata, fs, und;
  logic [5:0]  obs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uac_iis_spk_tx #(.BCLK_HALF(16), .SLOT_BITS(32)) dut (
    .i_clk98304     (clk),
    .i_reset        (rst),
    .i_enable       (en),
    .i_sample_width (width),
    .i_smp_val      (val),
    .o_smp_rdy      (rdy),
    .i_smp_l        (sl),
    .i_smp_r        (sr),
    .o_spk_iis_bclk (bclk),
    .o_spk_iis_lrck (lrck),
    .o_spk_iis_data (sdata),
    .o_frame_start  (fs),
    .o_underrun     (und)
  );

  assign obs = {bclk, lrck, sdata, fs, und, rdy};

  // Reference model: run-relative cycle count, one pending pair, current frame word.
  bit          m_on;
  int          m_rel;
  bit          m_hold_full;
  logic [31:0] m_hl, m_hr;
  logic [63:0] m_cur;
  logic        m_prev, m_und;
  bit          m_acc;

  function automatic logic [31:0] keep_top(input logic [31:0] v, input logic [1:0] w);
    int bits;
    logic [31:0] r;
    bits = (w == 2'd0) ? 16 : (w == 2'd1) ? 24 : 32;
    r = v;
    for (int i = 0; i < 32 - bits; i++) r[i] = 1'b0;
    return r;
  endfunction

  task automatic model_new_frame();
    m_prev = m_cur[0];
    m_und  = !m_hold_full;
    m_cur  = m_hold_full ? {keep_top(m_hl, width), keep_top(m_hr, width)} : 64'h0;
    m_hold_full = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_on = 1'b0; m_rel = 0; m_hold_full = 1'b0; m_cur = '0; m_prev = 1'b0; m_und = 1'b0;
      m_hl = '0; m_hr = '0;
    end else begin
      m_acc = m_on && !m_hold_full && val;
      if (!m_on) begin
        if (en) begin
          m_on = 1'b1; m_rel = 0;
          model_new_frame();
        end
      end else if (((m_rel + 1) % 2048 == 0) && !en) begin
        m_on = 1'b0; m_rel = 0; m_hold_full = 1'b0; m_cur = '0; m_acc = 1'b0;
      end else begin
        m_rel++;
        if (m_rel % 2048 == 0) model_new_frame();
      end
      if (m_acc) begin
        m_hold_full = 1'b1; m_hl = sl; m_hr = sr;
      end
    end
  end

  // Expected {bclk, lrck, data, frame_start, underrun, rdy} for the current cycle.
  function automatic logic [5:0] expected();
    int ph, n;
    logic b, l, d, f, u, r;
    if (!m_on) return 6'b0;
    ph = m_rel % 2048;
    n  = ph / 32;
    b  = (m_rel % 32) >= 16;
    l  = n >= 32;
    d  = (n == 0) ? m_prev : m_cur[64 - n];
    f  = (ph == 0);
    u  = f && m_und;
    r  = !m_hold_full;
    return {b, l, d, f, u, r};
  endfunction

  // Passive measurements: edge spacings, pulse counts, and the serial word of the last frame.
  int cyc = 0;
  int last_bclk = 0, last_lrck = 0, last_fs = 0;
  int bclk_per = 0, lrck_per = 0, fs_per = 0;
  int fs_cnt = 0, und_cnt = 0, und_alone = 0;
  logic p_bclk = 1'b0, p_lrck = 1'b0;
  logic [63:0] cap_cur = '0, cap_done = '0;
  logic cap_p0 = 1'b0;

  always @(negedge clk) begin
    int n;
    cyc++;
    if (bclk && !p_bclk) begin bclk_per = cyc - last_bclk; last_bclk = cyc; end
    if (lrck && !p_lrck) begin lrck_per = cyc - last_lrck; last_lrck = cyc; end
    if (fs) begin fs_per = cyc - last_fs; last_fs = cyc; fs_cnt++; end
    if (und) und_cnt++;
    if (und && !fs) und_alone++;
    p_bclk = bclk;
    p_lrck = lrck;
    if (m_on && (m_rel % 32 == 8)) begin
      n = (m_rel % 2048) / 32;
      if (n == 0) begin
        cap_done = {cap_cur[63:1], sdata};
        cap_p0   = sdata;
      end else begin
        cap_cur[64 - n] = sdata;
      end
    end
  end

  task automatic hard_reset();
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0; val = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic start_run();
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    en = 1'b1; val = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (obs !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_hold got=%b exp=%b", obs, 6'b0);
    end
    @(posedge clk); #1 rst = 1'b0; en = 1'b0; val = 1'b0;
    repeat (40) begin
      @(negedge clk);
      vectors++;
      if (obs !== expected()) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, obs, expected());
      end
    end
    start_run();
    repeat (700) begin
      @(negedge clk);
      vectors++;
      if (obs !== expected()) begin
        miscompares++;
        $display("FAIL reset_prerun cyc=%0d got=%b exp=%b", cyc, obs, expected());
      end
    end
    @(posedge clk); #2 rst = 1'b1;
    #1;
    vectors++;
    if (obs !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_async got=%b exp=%b", obs, 6'b0);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; en = 1'b0;
    repeat (50) begin
      @(negedge clk);
      vectors++;
      if (obs !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_after cyc=%0d got=%b exp=%b", cyc, obs, 6'b0);
      end
    end
  endtask

  task automatic test_width24();
    hard_reset();
    width = 2'd1; sl = 32'hA5A5A5FF; sr = 32'h123456FF; val = 1'b1;
    start_run();
    repeat (2 * 2048 + 40) begin
      @(negedge clk);
      vectors++;
      if (obs !== expected()) begin
        miscompares++;
        $display("FAIL width24 cyc=%0d got=%b exp=%b", cyc, obs, expected());
      end
    end
    @(posedge clk);
    vectors++;
    if (cap_done !== 64'hA5A5A500_12345600) begin
      miscompares++;
      $display("FAIL width24_word got=%h exp=%h", cap_done, 64'hA5A5A500_12345600);
    end
    vectors++;
    if (bclk_per !== 32) begin
      miscompares++;
      $display("FAIL bclk_period got=%0d exp=32", bclk_per);
    end
    vectors++;
    if (lrck_per !== 2048) begin
      miscompares++;
      $display("FAIL lrck_period got=%0d exp=2048", lrck_per);
    end
    vectors++;
    if (fs_per !== 2048) begin
      miscompares++;
      $display("FAIL frame_spacing got=%0d exp=2048", fs_per);
    end
  endtask

  task automatic test_underrun();
    int fs0, und0, alone0;
    hard_reset();
    width = 2'($urandom_range(0, 3)); sl = $urandom; sr = $urandom; val = 1'b0;
    fs0 = fs_cnt; und0 = und_cnt; alone0 = und_alone;
    start_run();
    repeat (3 * 2048) begin
      @(negedge clk);
      vectors++;
      if (obs !== expected()) begin
        miscompares++;
        $display("FAIL underrun cyc=%0d got=%b exp=%b", cyc, obs, expected());
      end
    end
    @(posedge clk);
    vectors++;
    if (fs_cnt - fs0 !== 3) begin
      miscompares++;
      $display("FAIL underrun_frames got=%0d exp=3", fs_cnt - fs0);
    end
    vectors++;
    if ((und_cnt - und0 !== 3) || (und_alone - alone0 !== 0)) begin
      miscompares++;
      $display("FAIL underrun_pulses got=%0d/%0d exp=3/0", und_cnt - und0, und_alone - alone0);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    logic rdy_s;
    hard_reset();
    width = 2'd2; k = 0;
    sl = 32'h1000_0000; sr = ~32'h1000_0000; val = 1'b1;
    start_run();
    repeat (5 * 2048) begin
      @(negedge clk);
      vectors++;
      if (obs !== expected()) begin
        miscompares++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, obs, expected());
      end
      rdy_s = rdy;
      @(posedge clk); #1;
      if (rdy_s && val) begin
        k++;
        sl = 32'h1000_0000 + 32'(k);
        sr = ~sl;
      end
    end
    vectors++;
    if (k !== 5) begin
      miscompares++;
      $display("FAIL accept_count got=%0d exp=5", k);
    end
  endtask

  task automatic test_width16();
    hard_reset();
    width = 2'd0; sl = 32'hFFFF_FFFF; sr = 32'hFFFF_FFFF; val = 1'b1;
    start_run();
    repeat (2 * 2048 + 40) begin
      @(negedge clk);
      vectors++;
      if (obs !== expected()) begin
        miscompares++;
        $display("FAIL width16 cyc=%0d got=%b exp=%b", cyc, obs, expected());
      end
    end
    @(posedge clk);
    vectors++;
    if (cap_done !== 64'hFFFF0000_FFFF0000) begin
      miscompares++;
      $display("FAIL width16_word got=%h exp=%h", cap_done, 64'hFFFF0000_FFFF0000);
    end
    vectors++;
    if (cap_p0 !== 1'b0) begin
      miscompares++;
      $display("FAIL width16_period0 got=%b exp=0", cap_p0);
    end
  endtask

  task automatic test_disable();
    logic rdy_s;
    hard_reset();
    width = 2'($urandom_range(0, 3)); sl = $urandom; sr = $urandom; val = 1'b1;
    start_run();
    for (int i = 0; i < 2 * 2048 + 100; i++) begin
      @(negedge clk);
      if (i == 2048 + 320) en = 1'b0;
      vectors++;
      if (obs !== expected()) begin
        miscompares++;
        $display("FAIL disable cyc=%0d got=%b exp=%b", cyc, obs, expected());
      end
      rdy_s = rdy;
      @(posedge clk); #1;
      if (rdy_s && val) begin
        sl = $urandom; sr = $urandom;
      end
    end
    @(negedge clk);
    vectors++;
    if (obs !== 6'b0) begin
      miscompares++;
      $display("FAIL disable_idle got=%b exp=%b", obs, 6'b0);
    end
    @(posedge clk); #1 en = 1'b1; val = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({fs, und, sdata} !== 3'b110) begin
      miscompares++;
      $display("FAIL reenable_underrun got=%b exp=110", {fs, und, sdata});
    end
    repeat (100) begin
      @(negedge clk);
      vectors++;
      if (obs !== expected()) begin
        miscompares++;
        $display("FAIL reenable cyc=%0d got=%b exp=%b", cyc, obs, expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_width24();
    test_underrun();
    test_back_to_back();
    test_width16();
    test_disable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
